// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - NOC router ingress FIFO with XY next-hop computed at write time
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   flit_i         incoming flit (destination coordinates in the low bits)
//   valid_i        write request for flit_i
//   grant_i        pop request (OR of this port's grants across output processors)
//   flit_o         head flit (don't-care when empty)
//   nexthop_addr_o next-hop code of the head flit, 3'b000 when empty
//   credit_o       registered one-cycle pulse per freed slot
//   full_o         buffer holds DEPTH flits
//   empty_o        buffer holds no flits
//   overflow_o     sticky: a write was dropped since reset
module input_port_buffer #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 2,
    parameter int DEPTH   = 4,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] flit_i,
    input  logic              valid_i,
    input  logic              grant_i,
    output logic [DATA_W-1:0] flit_o,
    output logic [2:0]        nexthop_addr_o,
    output logic              credit_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 3;

    localparam logic [2:0] HOP_NONE = 3'b000;
    localparam logic [2:0] HOP_N    = 3'b001;
    localparam logic [2:0] HOP_S    = 3'b010;
    localparam logic [2:0] HOP_W    = 3'b011;
    localparam logic [2:0] HOP_E    = 3'b100;
    localparam logic [2:0] HOP_L    = 3'b101;

    localparam logic [COORD_W-1:0] LX = LOCAL_X[COORD_W-1:0];
    localparam logic [COORD_W-1:0] LY = LOCAL_Y[COORD_W-1:0];

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              credit_q, credit_d;
    logic              overflow_q, overflow_d;

    logic              push;
    logic              pop;
    logic              drop;
    logic [2:0]        wr_hop;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [ENTRY_W-1:0] head;

    // With a power-of-two depth the count MSB is set only at count == DEPTH.
    assign full_o  = count_q[ADDR_W];
    assign empty_o = (count_q == '0);

    assign pop  = grant_i && !empty_o;
    // A pop in the same cycle frees a slot, so a full buffer still accepts the write.
    assign push = valid_i && (!full_o || pop);
    assign drop = valid_i && full_o && !pop;

    assign dest_x = flit_i[2*COORD_W-1:COORD_W];
    assign dest_y = flit_i[COORD_W-1:0];

    // XY dimension-order routing: resolve X first, then Y, else deliver locally.
    always_comb begin
        wr_hop = HOP_L;
        if (dest_x > LX) begin
            wr_hop = HOP_E;
        end else if (dest_x < LX) begin
            wr_hop = HOP_W;
        end else if (dest_y > LY) begin
            wr_hop = HOP_N;
        end else if (dest_y < LY) begin
            wr_hop = HOP_S;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        credit_d   = pop;
        overflow_d = overflow_q | drop;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {flit_i, wr_hop};
        end
    end

    assign head           = mem[rd_ptr_q];
    assign flit_o         = head[ENTRY_W-1:3];
    assign nexthop_addr_o = empty_o ? HOP_NONE : head[2:0];
    assign credit_o       = credit_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - scoreboard and vector-table bench for input_port_buffer
module tb_input_port_buffer;

    localparam int DATA_W  = 32;
    localparam int COORD_W = 2;
    localparam int DEPTH   = 4;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] flit_i;
    logic              valid_i;
    logic              grant_i;
    logic [DATA_W-1:0] flit_o;
    logic [2:0]        nexthop_addr_o;
    logic              credit_o;
    logic              full_o;
    logic              empty_o;
    logic              overflow_o;

    input_port_buffer #(
        .DATA_W (DATA_W),
        .COORD_W(COORD_W),
        .DEPTH  (DEPTH),
        .LOCAL_X(1),
        .LOCAL_Y(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flit_i        (flit_i),
        .valid_i       (valid_i),
        .grant_i       (grant_i),
        .flit_o        (flit_o),
        .nexthop_addr_o(nexthop_addr_o),
        .credit_o      (credit_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .overflow_o    (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dx;
        logic [1:0] dy;
        logic [2:0] hop;
    } vec_t;

    vec_t vecs [5];

    logic [DATA_W+2:0] sb [$];
    logic              credit_exp;
    logic              ovf_exp;
    int                n_vec;
    int                n_fail;

    function automatic void chk(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Independent XY model for LOCAL = (1,1).
    function automatic logic [2:0] ref_hop(input logic [DATA_W-1:0] f);
        logic [1:0] x;
        logic [1:0] y;
        x = f[3:2];
        y = f[1:0];
        if (x > 2'd1)      return 3'b100;
        else if (x < 2'd1) return 3'b011;
        else if (y > 2'd1) return 3'b001;
        else if (y < 2'd1) return 3'b010;
        else               return 3'b101;
    endfunction

    function automatic logic [DATA_W-1:0] mk_flit(input logic [1:0] x, input logic [1:0] y);
        logic [DATA_W-1:0] f;
        f = $urandom();
        f[3:0] = {x, y};
        return f;
    endfunction

    task automatic check_state();
        chk("empty_o", DATA_W'(empty_o), DATA_W'(sb.size() == 0));
        chk("full_o", DATA_W'(full_o), DATA_W'(sb.size() == DEPTH));
        chk("credit_o", DATA_W'(credit_o), DATA_W'(credit_exp));
        chk("overflow_o", DATA_W'(overflow_o), DATA_W'(ovf_exp));
        if (sb.size() == 0) begin
            chk("nexthop_empty", DATA_W'(nexthop_addr_o), '0);
        end else begin
            chk("head_flit", flit_o, sb[0][DATA_W+2:3]);
            chk("head_hop", DATA_W'(nexthop_addr_o), DATA_W'(sb[0][2:0]));
        end
    endtask

    // Called just after a falling edge: check state, drive inputs, advance one clock.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] f, input logic [2:0] hexp,
                         input logic g);
        logic pop_m;
        logic push_m;
        check_state();
        valid_i = v;
        flit_i  = f;
        grant_i = g;
        pop_m  = g && (sb.size() != 0);
        push_m = v && ((sb.size() < DEPTH) || pop_m);
        @(posedge clk);
        if (pop_m) void'(sb.pop_front());
        if (push_m) sb.push_back({f, hexp});
        if (v && !push_m) ovf_exp = 1'b1;
        credit_exp = pop_m;
        @(negedge clk);
        valid_i = 1'b0;
        grant_i = 1'b0;
    endtask

    task automatic push_flit(input logic [1:0] x, input logic [1:0] y);
        logic [DATA_W-1:0] f;
        f = mk_flit(x, y);
        cycle(1'b1, f, ref_hop(f), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 3'b000, 1'b1);
        end
        cycle(1'b0, '0, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_empty", DATA_W'(empty_o), 1);
        chk("rst_full", DATA_W'(full_o), 0);
        chk("rst_hop", DATA_W'(nexthop_addr_o), 0);
        chk("rst_credit", DATA_W'(credit_o), 0);
        chk("rst_ovf", DATA_W'(overflow_o), 0);
        sb.delete();
        credit_exp = 1'b0;
        ovf_exp    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_credit_held", DATA_W'(credit_o), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        valid_i = 1'b0;
        grant_i = 1'b0;
        flit_i = '0;
        reset = 1'b1;
        credit_exp = 1'b0;
        ovf_exp = 1'b0;

        vecs[0] = '{2'd2, 2'd1, 3'b100};
        vecs[1] = '{2'd0, 2'd1, 3'b011};
        vecs[2] = '{2'd1, 2'd2, 3'b001};
        vecs[3] = '{2'd1, 2'd0, 3'b010};
        vecs[4] = '{2'd1, 2'd1, 3'b101};

        @(negedge clk);
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 3'b000, 1'b0);

        // Route table: five writes, then five grants; DEPTH is 4 so write
        // four, start granting while the fifth goes in alongside a pop.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk_flit(vecs[i].dx, vecs[i].dy), vecs[i].hop, 1'b0);
        end
        cycle(1'b1, mk_flit(vecs[4].dx, vecs[4].dy), vecs[4].hop, 1'b1);
        drain();

        // Fill to full, then a dropped fifth write.
        for (int i = 0; i < 4; i++) push_flit(2'(i), 2'(3 - i));
        push_flit(2'd3, 2'd3);
        drain();

        // Full buffer with simultaneous write and grant.
        for (int i = 0; i < 4; i++) push_flit(2'(i), 2'd2);
        begin
            logic [DATA_W-1:0] f;
            f = mk_flit(2'd1, 2'd1);
            cycle(1'b1, f, ref_hop(f), 1'b1);
        end
        drain();

        // Clear the sticky overflow for the remaining sequences.
        do_reset();

        // Grant while empty, then six writes under continuous grant.
        cycle(1'b0, '0, 3'b000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [DATA_W-1:0] f;
            f = mk_flit(2'(i % 4), 2'((i + 1) % 4));
            cycle(1'b1, f, ref_hop(f), 1'b1);
        end
        drain();

        // Reset with three flits held and a grant in flight.
        for (int i = 0; i < 3; i++) push_flit(2'd0, 2'(i));
        cycle(1'b0, '0, 3'b000, 1'b1);
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Per-port ingress stage of the NOC router: buffers single-flit packets arriving from a neighbouring router or the local PE and computes the XY next hop for each flit as it is written. It presents the head flit and its 3-bit next-hop code to the five round-robin output processors. It pops the head when the arbiter grants this port and returns one credit upstream per freed slot. One instance sits on each of the N, S, W, E and L inputs.

## Interface
- DATA_W, 32, flit width; destination coordinates live in the low bits.
- COORD_W, 2, width of each destination coordinate; dest_x = flit[2*COORD_W-1:COORD_W], dest_y = flit[COORD_W-1:0].
- DEPTH, 4, FIFO slots; must be a power of two, minimum 2.
- LOCAL_X, 0, this router's X coordinate.
- LOCAL_Y, 0, this router's Y coordinate.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flit_i  in  DATA_W  incoming flit.
- valid_i  in  1  flit_i is valid this cycle (write request).
- grant_i  in  1  this port won arbitration at some output this cycle (pop request); it is the OR of that port's grant outputs across the five output processors.
- flit_o  out  DATA_W  head flit.
- nexthop_addr_o  out  3  next-hop code of the head flit; 3'b000 when empty.
- credit_o  out  1  one-cycle pulse: one slot was freed.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- overflow_o  out  1  sticky error: a write was dropped.

## Operation
- Next-hop encoding: 3'b000 none, 3'b001 N, 3'b010 S, 3'b011 W, 3'b100 E, 3'b101 L. Codes 110 and 111 are never produced.
- XY route, computed at write time and stored with the flit:
  - dest_x > LOCAL_X → E; dest_x < LOCAL_X → W.
  - Otherwise dest_y > LOCAL_Y → N; dest_y < LOCAL_Y → S.
  - Otherwise → L.
  - Comparisons are unsigned on COORD_W bits.
- Storage: circular buffer of DEPTH entries, each DATA_W + 3 bits wide.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
- Push: taken when valid_i && (!full_o || pop).
- Pop: taken when grant_i && !empty_o. grant_i while empty is ignored: no pointer change and no credit.
- Simultaneous push and pop:
  - When not empty, count is unchanged and both pointers advance.
  - When full, the push is accepted because the pop frees a slot in the same cycle.
  - When empty, only the push is taken.
- Dropped write: valid_i && full_o && !pop. The flit is discarded, overflow_o is set, and it stays set until reset.
- flit_o and nexthop_addr_o are read combinationally from the head entry. When empty, flit_o is don't-care and nexthop_addr_o is forced to 3'b000.
- Credits: the upstream sender starts with DEPTH credits. credit_o is registered: it is high in cycle k+1 exactly when a pop occurred in cycle k.

## Timing
- Reset (reset = 0, asynchronous assert):
  - pointers 0, count 0, credit_o 0, overflow_o 0.
  - empty_o 1, full_o 0, nexthop_addr_o 3'b000.
  - Storage contents are not reset.
- Reset deassertion is synchronised externally. The first push may occur on the first edge with reset = 1.
- Write-to-head latency: a flit written into an empty buffer at edge k appears on flit_o and nexthop_addr_o after edge k, so the arbiter can grant it in cycle k+1. There is no fall-through in the write cycle.
- Pop latency: grant_i sampled at edge k advances the head after edge k; the next flit or 3'b000 is visible in cycle k+1.
- Back-to-back grants drain one flit per cycle.
- Reset asserted mid-operation flushes all entries immediately and suppresses any pending credit pulse.

## Test plan
- Reset, then idle: empty_o = 1, nexthop_addr_o = 000, credit_o = 0, overflow_o = 0 for 5 cycles.
- LOCAL = (1,1); write destinations (2,1), (0,1), (1,2), (1,0), (1,1) on consecutive cycles, then grant one per cycle → nexthop_addr_o sequence 100, 011, 001, 010, 101, then 000. credit_o pulses 5 times, each one cycle after its grant.
- DEPTH = 4: write 4 flits → full_o = 1. A 5th write without a grant → overflow_o = 1 and that flit is absent when draining (exactly 4 flits come out in order).
- Full buffer plus simultaneous valid_i and grant_i → write accepted, full_o stays 1, overflow_o stays 0, FIFO order preserved.
- Grant while empty → no credit_o, pointers unchanged. Then write 6 flits and grant continuously → pointer wrap-around and in-order output of all 6.
- Assert reset while holding 3 flits with a grant in flight → empty_o = 1 immediately, nexthop_addr_o = 000, no credit pulse in the following cycle.
